writeback_unit: RTL and testbench

Write-side companion of `registerfile`: collects results from the single-cycle ALU path and the variable-latency load path, arbitrates them onto the register file's single write port, and keeps a per-register pending-write scoreboard for the issue stage. It sits between execute/memory and `registerfile`, driving `write`, `reg_wr` and `data_in` directly. Writes to x0 are discarded, and a starvation counter guarantees forward progress for buffered loads.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/writeback_unit.sv | 103 ++++++++++
 tb/tb_writeback_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file types for the writeback path
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result buffer, power-of-two depth, pointers wrap naturally
module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T               mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - ALU/load arbitration onto the register file write port with busy scoreboard
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int NUM_REGISTERS = NREGS,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT  = 8,
  localparam int AW           = $clog2(NUM_REGISTERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_stall,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_rd,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     write,
  output logic [AW-1:0]            reg_wr,
  output logic [DATA_WIDTH-1:0]    data_in,
  output logic [NUM_REGISTERS-1:0] busy
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t               head, win;
  logic                    full, empty, push, pop, win_valid, commit;
  logic                    write_q, write_d, stall_q, stall_d;
  logic [AW-1:0]           reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NUM_REGISTERS-1:0] busy_q, busy_d;
  logic [WW-1:0]           wait_q, wait_d;

  assign ld_ready = !full;
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && !empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wb_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{rd: ld_rd, data: ld_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    win       = alu_valid ? '{rd: alu_rd, data: alu_data} : head;
    win_valid = alu_valid || !empty;
    commit    = win_valid && (win.rd != REG_ZERO);

    write_d  = commit;
    reg_wr_d = commit ? win.rd : reg_wr_q;
    data_d   = commit ? win.data : data_q;

    // Saturating count of consecutive lost arbitrations for the current head.
    if (empty || pop)                         wait_d = '0;
    else if (wait_q == WW'(STARVE_LIMIT - 1)) wait_d = wait_q;
    else                                      wait_d = wait_q + WW'(1);
    stall_d = !empty && !pop && (wait_q == WW'(STARVE_LIMIT - 1));

    // Set after clear: a newly issued writer owns the register over a retiring one.
    busy_d = busy_q;
    if (commit) busy_d[win.rd] = 1'b0;
    if (issue_valid && issue_rd != REG_ZERO) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q  <= 1'b0;
      reg_wr_q <= '0;
      data_q   <= '0;
      busy_q   <= '0;
      stall_q  <= 1'b0;
      wait_q   <= '0;
    end else begin
      write_q  <= write_d;
      reg_wr_q <= reg_wr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      wait_q   <= wait_d;
    end
  end

  assign write     = write_q;
  assign reg_wr    = reg_wr_q;
  assign data_in   = data_q;
  assign busy      = busy_q;
  assign alu_stall = stall_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - vector table, corner sequences and random run against a queue model
module tb_writeback_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, alu_valid, ld_valid;
  logic [4:0]  issue_rd, alu_rd, ld_rd;
  logic [31:0] alu_data, ld_data;
  logic        alu_stall, ld_ready, write;
  logic [4:0]  reg_wr;
  logic [31:0] data_in, busy;

  always #5 clk = ~clk;

  writeback_unit #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .write(write), .reg_wr(reg_wr), .data_in(data_in), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [4:0] rd; logic [31:0] data; } ld_t;
  ld_t         mq[$];
  int          m_loss;
  bit          m_stall, m_write;
  logic [4:0]  m_reg;
  logic [31:0] m_data, m_busy;

  task automatic model_reset();
    mq.delete();
    m_loss = 0; m_stall = 0; m_write = 0;
    m_reg = '0; m_data = '0; m_busy = '0;
  endtask

  task automatic set_in(input logic iv, input logic [4:0] ird, input logic av, input logic [4:0] ard,
                        input logic [31:0] adat, input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    issue_valid = iv; issue_rd = ird; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
  endtask

  // One clock: advance the model from the current inputs, then compare after the edge.
  task automatic step();
    bit          popped, win, ready;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    ready = (mq.size() < DEPTH);
    popped = 0; win = 0; wrd = '0; wdat = '0;
    if (alu_valid) begin
      win = 1; wrd = alu_rd; wdat = alu_data;
    end else if (mq.size() > 0) begin
      win = 1; wrd = mq[0].rd; wdat = mq[0].data; popped = 1;
    end
    if (mq.size() == 0 || popped) m_loss = 0;
    else m_loss++;
    m_stall = (mq.size() > 0) && !popped && (m_loss >= LIMIT);
    m_write = win && (wrd != 0);
    if (m_write) begin
      m_reg = wrd; m_data = wdat; m_busy[wrd] = 1'b0;
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (popped) void'(mq.pop_front());
    if (ld_valid && ready) mq.push_back('{rd: ld_rd, data: ld_data});
    @(posedge clk);
    #1;
    chk("write", 64'(write), 64'(m_write));
    chk("reg_wr", 64'(reg_wr), 64'(m_reg));
    chk("data_in", 64'(data_in), 64'(m_data));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("alu_stall", 64'(alu_stall), 64'(m_stall));
    chk("ld_ready", 64'(ld_ready), 64'(mq.size() < DEPTH));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic iv; logic [4:0] ird; logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic e_write; logic [4:0] e_reg; logic [31:0] e_data; logic [31:0] e_busy;
  } vec_t;

  vec_t vt[8];
  int   order[$];

  initial begin
    int n;
    int acc_at;

    vt[0] = '{1, 5, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,        32'h20};
    vt[1] = '{0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  1, 5, 32'hDEADBEEF, 32'h0};
    vt[2] = '{0, 0, 1, 0, 32'h12345678, 0, 0, 32'h0,  0, 5, 32'hDEADBEEF, 32'h0};
    vt[3] = '{1, 3, 0, 0, 32'h0,        1, 3, 32'h33, 0, 5, 32'hDEADBEEF, 32'h08};
    vt[4] = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 3, 32'h33,       32'h0};
    vt[5] = '{0, 0, 0, 0, 32'h0,        1, 0, 32'h55, 0, 3, 32'h33,       32'h0};
    vt[6] = '{0, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 3, 32'h33,       32'h0};
    vt[7] = '{1, 9, 1, 9, 32'hA5A5A5A5, 0, 0, 32'h0,  1, 9, 32'hA5A5A5A5, 32'h200};

    do_reset();
    chk("rst_write", 64'(write), 64'(0));
    chk("rst_reg_wr", 64'(reg_wr), 64'(0));
    chk("rst_data_in", 64'(data_in), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(alu_stall), 64'(0));
    chk("rst_ready", 64'(ld_ready), 64'(1));

    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].iv, vt[i].ird, vt[i].av, vt[i].ard, vt[i].adat, vt[i].lv, vt[i].lrd, vt[i].ldat);
      step();
      chk($sformatf("vec%0d_write", i), 64'(write), 64'(vt[i].e_write));
      chk($sformatf("vec%0d_reg_wr", i), 64'(reg_wr), 64'(vt[i].e_reg));
      chk($sformatf("vec%0d_data_in", i), 64'(data_in), 64'(vt[i].e_data));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
    end

    // FIFO fill: four loads while the ALU owns the port, then drain.
    do_reset();
    order.delete();
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 1, 10, $urandom, 1, 5'(i), 32'h100 + 32'(i));
      step();
    end
    chk("fill_ready_low", 64'(ld_ready), 64'(0));
    acc_at = -1;
    set_in(0, 0, 0, 0, 0, 1, 5, 32'h105);
    for (int c = 0; c < 10 && acc_at < 0; c++) begin
      if (ld_ready) acc_at = c;
      step();
      if (write) order.push_back(int'(reg_wr));
    end
    chk("fill_fifth_accept_cycle", 64'(acc_at), 64'(1));
    ld_valid = 0;
    for (int c = 0; c < 20 && order.size() < 5; c++) begin
      step();
      if (write) order.push_back(int'(reg_wr));
    end
    chk("fill_write_count", 64'(order.size()), 64'(5));
    for (int i = 0; i < order.size() && i < 5; i++)
      chk($sformatf("fill_order%0d", i), 64'(order[i]), 64'(i + 1));

    // Starvation: one buffered load versus a continuous ALU stream.
    do_reset();
    set_in(0, 0, 1, 11, 32'h11, 1, 6, 32'h66);
    step();
    ld_valid = 0;
    n = 0;
    while (!alu_stall && n < 20) begin
      alu_data = $urandom;
      step();
      n++;
    end
    chk("starve_cycles", 64'(n), 64'(LIMIT));
    alu_valid = 0;
    step();
    chk("starve_write", 64'(write), 64'(1));
    chk("starve_reg_wr", 64'(reg_wr), 64'(6));
    chk("starve_data", 64'(data_in), 64'(32'h66));
    chk("starve_stall_drop", 64'(alu_stall), 64'(0));

    // Scoreboard race: reissue of x7 in the same cycle its result retires.
    do_reset();
    set_in(1, 7, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    set_in(1, 7, 1, 7, 32'h77, 0, 0, 0); step();
    chk("race_write", 64'(write), 64'(1));
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("race_busy7", 64'(busy[7]), 64'(1));

    // Reset mid-operation with three buffered loads.
    do_reset();
    for (int i = 5; i <= 7; i++) begin
      set_in(1, 5'(i), 1, 12, 32'hC0, 1, 5'(i), 32'(i));
      step();
    end
    chk("mid_busy", 64'(busy), 64'(32'h0000_00E0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_write", 64'(write), 64'(0));
    chk("mid_rst_reg_wr", 64'(reg_wr), 64'(0));
    chk("mid_rst_data", 64'(data_in), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_stall", 64'(alu_stall), 64'(0));
    chk("mid_rst_ready", 64'(ld_ready), 64'(1));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_write", 64'(write), 64'(0));
    end

    // Randomized traffic, mostly honouring alu_stall.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom % 3) == 0, 5'($urandom), (!alu_stall || ($urandom % 16 == 0)) && ($urandom % 2 == 0),
             5'($urandom % 8), $urandom, ($urandom % 3) != 0, 5'($urandom % 8), $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
